// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and field helpers for the branch predictor
//
// Purpose : prediction-mode encodings, PC index/tag extraction and the PHT
//           saturating-counter next-value function used by branch_predictor.
// Ports   : none (package).
package bp_pkg;

  localparam int PRED_STATIC  = 0;
  localparam int PRED_BIMODAL = 1;
  localparam int PRED_GSHARE  = 2;

  // Helpers work on a wide PC so any XLEN up to 64 fits; callers size-cast
  // the result down to the field width they need.
  localparam int PC_MAX = 64;

  // Word-aligned table index: pc[idxBits+1:2].
  function automatic logic [PC_MAX-1:0] pcIndex(input logic [PC_MAX-1:0] pc,
                                                input int idxBits);
    return (pc >> 2) & ((PC_MAX'(1) << idxBits) - PC_MAX'(1));
  endfunction

  // Tag bits sit directly above the index: pc[idxBits+tagBits+1:idxBits+2].
  function automatic logic [PC_MAX-1:0] pcTag(input logic [PC_MAX-1:0] pc,
                                              input int idxBits,
                                              input int tagBits);
    return (pc >> (idxBits + 2)) & ((PC_MAX'(1) << tagBits) - PC_MAX'(1));
  endfunction

  // Saturating up/down step for a counter of ctrBits (<= 8) bits.
  function automatic logic [7:0] ctrNext(input logic [7:0] ctr,
                                         input logic taken,
                                         input int ctrBits);
    int ctrMax;
    ctrMax = (1 << ctrBits) - 1;
    if (taken) return (int'(ctr) == ctrMax) ? ctr : ctr + 8'd1;
    else       return (ctr == 8'd0) ? ctr : ctr - 8'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating event counter with enable and async clear
//
// Purpose : counts enabled cycles and holds at all-ones instead of wrapping.
// Ports   : clock  - rising-edge clock
//           reset  - asynchronous active-low clear
//           enable - count this cycle
//           count  - current value
module bp_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + PHT dynamic branch predictor for the RV32 pipeline
//
// Purpose : IF-stage combinational next-PC prediction (static / bimodal /
//           gshare) and MEM-stage training, mispredict detection and redirect.
// Ports   : clock, reset (async active-low)
//           fetch_pc -> pred_hit, pred_taken, pred_npc          (IF lookup)
//           upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
//           upd_target, upd_pred_taken, upd_pred_npc            (MEM resolve)
//           mispredict, redirect_pc                             (redirect)
//           perf_branches, perf_mispredicts                     (saturating)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 6,
  parameter int PRED_MODE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_npc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDXW = $clog2(ENTRIES);
  // Weak not-taken start point (0 for a 1-bit counter).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                btbValid  [ENTRIES];
  logic [TAG_BITS-1:0] btbTag    [ENTRIES];
  logic [XLEN-1:0]     btbTarget [ENTRIES];
  logic                btbIsJump [ENTRIES];
  logic [CTR_BITS-1:0] pht       [ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  logic [IDXW-1:0]     fetchIdx, fetchPhtIdx, updIdx, updPhtIdx;
  logic [TAG_BITS-1:0] fetchTag, updTag;
  logic                updIsCti, actTaken, updTagHit;
  logic [XLEN-1:0]     actNpc;
  logic [CTR_BITS-1:0] phtNext;

  assign fetchIdx = IDXW'(pcIndex(PC_MAX'(fetch_pc), IDXW));
  assign fetchTag = TAG_BITS'(pcTag(PC_MAX'(fetch_pc), IDXW, TAG_BITS));
  assign updIdx   = IDXW'(pcIndex(PC_MAX'(upd_pc), IDXW));
  assign updTag   = TAG_BITS'(pcTag(PC_MAX'(upd_pc), IDXW, TAG_BITS));

  // Gshare hashes history into the PHT index only; the BTB is always indexed
  // by PC so a target survives history changes.
  assign fetchPhtIdx = (PRED_MODE == PRED_GSHARE) ? (fetchIdx ^ IDXW'(ghr)) : fetchIdx;
  assign updPhtIdx   = (PRED_MODE == PRED_GSHARE) ? (updIdx ^ IDXW'(ghr)) : updIdx;

  // ---------------- IF lookup (reads pre-update table contents) ----------------
  assign pred_hit   = btbValid[fetchIdx] && (btbTag[fetchIdx] == fetchTag);
  assign pred_taken = (PRED_MODE != PRED_STATIC) && pred_hit &&
                      (btbIsJump[fetchIdx] || pht[fetchPhtIdx][CTR_BITS-1]);
  assign pred_npc   = pred_taken ? btbTarget[fetchIdx] : fetch_pc + XLEN'(4);

  // ---------------- MEM resolve ----------------
  assign updIsCti    = upd_is_branch | upd_is_jump;
  assign actTaken    = updIsCti & upd_taken;
  assign actNpc      = actTaken ? upd_target : upd_pc + XLEN'(4);
  // Comparing the full next PC also catches a taken jalr whose target moved.
  assign mispredict  = upd_valid & ((actTaken != upd_pred_taken) | (actNpc != upd_pred_npc));
  assign redirect_pc = actNpc;

  assign updTagHit = btbValid[updIdx] && (btbTag[updIdx] == updTag);
  assign phtNext   = CTR_BITS'(ctrNext(8'(pht[updPhtIdx]), upd_taken, CTR_BITS));

  // Valid bits, counters and history carry reset state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btbValid[i] <= 1'b0;
        pht[i]      <= CTR_INIT;
      end
      ghr <= '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        pht[updPhtIdx] <= phtNext;
        if (PRED_MODE == PRED_GSHARE) ghr <= GHR_BITS'({ghr, upd_taken});
      end
      if (actTaken) begin
        btbValid[updIdx] <= 1'b1;
      end else if (!updIsCti && updTagHit) begin
        // A non-control instruction owns this PC: drop the stale alias entry.
        btbValid[updIdx] <= 1'b0;
      end
    end
  end

  // BTB payload needs no reset; it is only observed through a set valid bit.
  always_ff @(posedge clock) begin
    if (upd_valid && actTaken) begin
      btbTag[updIdx]    <= updTag;
      btbTarget[updIdx] <= upd_target;
      btbIsJump[updIdx] <= upd_is_jump;
    end
  end

  bp_sat_counter #(.WIDTH(32)) uPerfBranches (
    .clock  (clock),
    .reset  (reset),
    .enable (upd_valid & updIsCti),
    .count  (perf_branches)
  );

  bp_sat_counter #(.WIDTH(32)) uPerfMispredicts (
    .clock  (clock),
    .reset  (reset),
    .enable (mispredict),
    .count  (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor (bimodal and gshare)
module tb_branch_predictor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] fetchPc;
  logic        updValid, updIsBranch, updIsJump, updTaken, updPredTaken;
  logic [31:0] updPc, updTarget, updPredNpc;

  logic        aHit, aTaken, aMis, bHit, bTaken, bMis;
  logic [31:0] aNpc, aRedir, aPerfBr, aPerfMis, bNpc, bRedir, bPerfBr, bPerfMis;

  branch_predictor #(.PRED_MODE(1)) dutBimodal (
    .clock(clock), .reset(reset), .fetch_pc(fetchPc),
    .pred_hit(aHit), .pred_taken(aTaken), .pred_npc(aNpc),
    .upd_valid(updValid), .upd_pc(updPc), .upd_is_branch(updIsBranch),
    .upd_is_jump(updIsJump), .upd_taken(updTaken), .upd_target(updTarget),
    .upd_pred_taken(updPredTaken), .upd_pred_npc(updPredNpc),
    .mispredict(aMis), .redirect_pc(aRedir),
    .perf_branches(aPerfBr), .perf_mispredicts(aPerfMis)
  );

  branch_predictor #(.PRED_MODE(2)) dutGshare (
    .clock(clock), .reset(reset), .fetch_pc(fetchPc),
    .pred_hit(bHit), .pred_taken(bTaken), .pred_npc(bNpc),
    .upd_valid(updValid), .upd_pc(updPc), .upd_is_branch(updIsBranch),
    .upd_is_jump(updIsJump), .upd_taken(updTaken), .upd_target(updTarget),
    .upd_pred_taken(updPredTaken), .upd_pred_npc(updPredNpc),
    .mispredict(bMis), .redirect_pc(bRedir),
    .perf_branches(bPerfBr), .perf_mispredicts(bPerfMis)
  );

  // Observable selectors: 0..6 bimodal instance, 10..16 gshare instance.
  localparam int HIT = 0, TAKEN = 1, NPC = 2, MIS = 3, REDIR = 4, PBR = 5, PMIS = 6, G = 10;

  typedef struct {
    int          sel;
    logic [31:0] expVal;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      HIT:       return {31'd0, aHit};
      TAKEN:     return {31'd0, aTaken};
      NPC:       return aNpc;
      MIS:       return {31'd0, aMis};
      REDIR:     return aRedir;
      PBR:       return aPerfBr;
      PMIS:      return aPerfMis;
      G + HIT:   return {31'd0, bHit};
      G + TAKEN: return {31'd0, bTaken};
      G + NPC:   return bNpc;
      G + MIS:   return {31'd0, bMis};
      G + REDIR: return bRedir;
      G + PBR:   return bPerfBr;
      G + PMIS:  return bPerfMis;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are combinational, so they are presented every cycle;
  // drain all expectations queued for this cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      while (sbq.size() > 0) begin
        chk_t c;
        logic [31:0] act;
        c   = sbq.pop_front();
        act = observe(c.sel);
        nChecks++;
        if (act !== c.expVal) begin
          nFails++;
          $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", c.name, act, c.expVal, $time);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input string n);
    chk_t c;
    c.sel = sel; c.expVal = v; c.name = n;
    sbq.push_back(c);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    updValid = 1'b0; updPc = '0; updIsBranch = 1'b0; updIsJump = 1'b0;
    updTaken = 1'b0; updTarget = '0; updPredTaken = 1'b0; updPredNpc = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                     input logic [31:0] tgt, input logic pt, input logic [31:0] pn);
    updValid = 1'b1; updPc = pc; updIsBranch = br; updIsJump = jmp;
    updTaken = tk; updTarget = tgt; updPredTaken = pt; updPredNpc = pn;
  endtask

  // Gshare T/N trace at 0x60, bit k = step k+1 (hand-derived history/PHT walk).
  logic [11:0] gOutcome, gPred, gMis;

  initial begin
    reset = 1'b0;
    fetchPc = 32'h100;
    idle();
    repeat (2) next_cycle();
    reset = 1'b1;
    expect_val(HIT, 0, "rst_hit");
    expect_val(TAKEN, 0, "rst_taken");
    expect_val(NPC, 32'h104, "rst_npc");
    expect_val(MIS, 0, "rst_mis_idle");
    expect_val(PBR, 0, "rst_perf_br");
    expect_val(PMIS, 0, "rst_perf_mis");

    // First taken branch at 0x40, lookup sees pre-update tables.
    next_cycle();
    fetchPc = 32'h40;
    upd(32'h40, 1, 0, 1, 32'h20, 0, 32'h44);
    expect_val(HIT, 0, "b40_pre_hit");
    expect_val(NPC, 32'h44, "b40_pre_npc");
    expect_val(MIS, 1, "b40_mis");
    expect_val(REDIR, 32'h20, "b40_redirect");

    next_cycle();
    idle();
    expect_val(HIT, 1, "b40_hit");
    expect_val(TAKEN, 1, "b40_taken");
    expect_val(NPC, 32'h20, "b40_npc");
    expect_val(PBR, 1, "perf_br_1");
    expect_val(PMIS, 1, "perf_mis_1");

    // Three more taken: counter reaches 11.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      upd(32'h40, 1, 0, 1, 32'h20, 1, 32'h20);
      expect_val(MIS, 0, "b40_trained_mis");
    end

    next_cycle();
    upd(32'h40, 1, 0, 0, 32'h20, 1, 32'h20);
    expect_val(MIS, 1, "b40_nt1_mis");
    expect_val(REDIR, 32'h44, "b40_nt1_redirect");
    next_cycle();
    idle();
    expect_val(TAKEN, 1, "b40_after_nt1_taken");
    expect_val(NPC, 32'h20, "b40_after_nt1_npc");

    next_cycle();
    upd(32'h40, 1, 0, 0, 32'h20, 1, 32'h20);
    expect_val(MIS, 1, "b40_nt2_mis");
    next_cycle();
    idle();
    expect_val(HIT, 1, "b40_after_nt2_hit");
    expect_val(TAKEN, 0, "b40_after_nt2_taken");
    expect_val(NPC, 32'h44, "b40_after_nt2_npc");
    expect_val(PBR, 6, "perf_br_6");
    expect_val(PMIS, 3, "perf_mis_3");

    // jal then jalr with a new target at 0x80.
    next_cycle();
    upd(32'h80, 0, 1, 1, 32'h200, 0, 32'h84);
    expect_val(MIS, 1, "jal_mis");
    expect_val(REDIR, 32'h200, "jal_redirect");
    next_cycle();
    fetchPc = 32'h80;
    upd(32'h80, 0, 1, 1, 32'h300, 1, 32'h200);
    expect_val(TAKEN, 1, "jal_pred_taken");
    expect_val(NPC, 32'h200, "jal_pred_npc");
    expect_val(MIS, 1, "jalr_mis");
    expect_val(REDIR, 32'h300, "jalr_redirect");
    next_cycle();
    idle();
    expect_val(NPC, 32'h300, "jalr_btb_target");

    // Alias 0x140 vs 0x40, then non-branch at 0x40 clears the entry.
    next_cycle();
    fetchPc = 32'h140;
    upd(32'h40, 0, 0, 0, 32'h0, 1, 32'h20);
    expect_val(HIT, 0, "alias_hit");
    expect_val(NPC, 32'h144, "alias_npc");
    expect_val(MIS, 1, "nonbr_mis");
    expect_val(REDIR, 32'h44, "nonbr_redirect");
    next_cycle();
    idle();
    fetchPc = 32'h40;
    expect_val(HIT, 0, "b40_cleared_hit");
    expect_val(PBR, 8, "perf_br_8");
    expect_val(PMIS, 6, "perf_mis_6");

    next_cycle();
    fetchPc = 32'hFFFF_FFFC;
    expect_val(NPC, 32'h0, "npc_wrap");

    // Fresh start for gshare.
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    gOutcome = 12'h555;
    gPred    = 12'h500;
    gMis     = 12'h055;
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      fetchPc = 32'h60;
      upd(32'h60, 1, 0, gOutcome[k], 32'h10, gPred[k], gPred[k] ? 32'h10 : 32'h64);
      expect_val(G + TAKEN, {31'd0, gPred[k]}, $sformatf("gs_pred_step%0d", k + 1));
      expect_val(G + NPC, gPred[k] ? 32'h10 : 32'h64, $sformatf("gs_npc_step%0d", k + 1));
      expect_val(G + MIS, {31'd0, gMis[k]}, $sformatf("gs_mis_step%0d", k + 1));
    end
    next_cycle();
    idle();
    expect_val(G + TAKEN, 1, "gs_final_taken");
    expect_val(G + PBR, 12, "gs_perf_br");
    expect_val(G + PMIS, 4, "gs_perf_mis");

    // Async reset in the middle of an update cycle.
    next_cycle();
    fetchPc = 32'h60;
    upd(32'h60, 1, 0, 1, 32'h10, 0, 32'h64);
    #2;
    reset = 1'b0;
    expect_val(G + HIT, 0, "rstmid_hit");
    expect_val(G + TAKEN, 0, "rstmid_taken");
    expect_val(G + NPC, 32'h64, "rstmid_npc");
    expect_val(G + MIS, 1, "rstmid_mis_comb");
    expect_val(G + REDIR, 32'h10, "rstmid_redirect");
    expect_val(G + PBR, 0, "rstmid_perf_br");
    expect_val(G + PMIS, 0, "rstmid_perf_mis");
    expect_val(PBR, 0, "rstmid_bimodal_perf_br");
    next_cycle();
    idle();
    reset = 1'b1;
    expect_val(G + HIT, 0, "rstmid_discarded_hit");
    expect_val(G + MIS, 0, "rstmid_after_mis");
    expect_val(G + PBR, 0, "rstmid_after_perf_br");

    repeat (2) next_cycle();
    if (sbq.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
